uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single uart_tx transmitter between two byte sources.
- Requester 0: cipher output stream from the enigma state machine. It pulses and cannot be stalled, so it is buffered in a FIFO.
- Requester 1: status/echo source with a valid/ready handshake.
- Sits between those sources and uart_tx in the top level. Sequences one byte at a time: issue DV, wait for Done, repeat.

Parameters:
- FIFO_DEPTH, 8, requester-0 buffer depth; power of 2, ≥2.
- DATA_W, 8, byte width.

Ports:
- i_Clk  in  1  system clock (PLL output).
- i_Rst_n  in  1  synchronous active-low reset.
- i_Req0_DV  in  1  1-cycle strobe, cipher byte valid; no backpressure.
- i_Req0_Byte  in  DATA_W  cipher byte.
- o_Req0_Ovf  out  1  sticky: a req0 byte was dropped.
- i_Req1_Valid  in  1  status byte pending.
- i_Req1_Byte  in  DATA_W  status byte, held while valid.
- o_Req1_Ready  out  1  1-cycle accept pulse for req1.
- o_Tx_DV  out  1  1-cycle start strobe to uart_tx.
- o_Tx_Byte  out  DATA_W  registered byte to uart_tx.
- i_Tx_Active  in  1  uart_tx busy.
- i_Tx_Done  in  1  uart_tx frame-complete pulse.
- o_Grant  out  1  requester owning the current/last transfer.
- o_Busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset: all outputs 0 and FIFO emptied. Sequencing state = IDLE; round-robin pointer last = 1, so req0 wins the first tie.
- Reset is synchronous only; in-flight req1 handshakes are abandoned.
- Reset mid-frame: uart_tx has no reset and finishes its frame. The arbiter must not grant while i_Tx_Active=1.
- FIFO write: i_Req0_DV=1 and not full → push; count is visible the next cycle.
- FIFO full:
  - DV=1 with no pop that cycle → byte dropped, o_Req0_Ovf←1 (cleared only by reset).
  - Push and pop in the same cycle while full → accepted, count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- States: IDLE → SEND → WAIT_DONE → GAP → IDLE.
- IDLE: grant only when i_Tx_Active=0.
  - p0 = FIFO non-empty; p1 = i_Req1_Valid.
  - Only one pending → grant it.
  - Both pending → grant !last.
  - On grant: load o_Tx_Byte, set o_Grant and last, go to SEND.
  - Grant 0 → pop FIFO. Grant 1 → o_Req1_Ready=1 this cycle.
- SEND: o_Tx_DV=1 for exactly one cycle → WAIT_DONE.
- WAIT_DONE: hold o_Tx_Byte; on i_Tx_Done=1 → GAP.
- GAP: one idle cycle so uart_tx's Active deasserts → IDLE.
- Latency, req0 into an idle arbiter:
  - DV at cycle N → grant at N+1 → o_Tx_DV at N+2.
- Latency, req1 into an idle arbiter:
  - Valid at N → Ready at N → o_Tx_DV at N+1.
- Back-to-back bytes are spaced by the uart_tx frame time plus 2 cycles (GAP and the IDLE grant cycle).
- i_Tx_Done outside WAIT_DONE is ignored.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: strict priority to req1 (status); req0 is served only when i_Req1_Valid=0. The last pointer is unused.
- Undefined (default): round-robin as above.
- o_Grant semantics are unchanged in both builds.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, SEND, WAIT_DONE, GAP);
  - requester index constants REQ_CIPHER=0, REQ_STATUS=1;
  - DATA_W default.
- Sub-module byte_fifo: synchronous FIFO with push/pop/full/empty/count. The arbiter owns the overflow flag.

Test Plan:
1. Single req0 byte 0x41, Done returned 2170 cycles after DV → o_Tx_DV pulse exactly 2 cycles after i_Req0_DV, o_Tx_Byte=0x41, o_Grant=0, FIFO empty, o_Busy falls 2 cycles after Done.
2. Req0 bytes 0x10,0x11 and req1 byte 0x7E all pending → grant order 0x10, 0x7E, 0x11 (round-robin); with ARB_FIXED_PRIO_EN: 0x7E, 0x10, 0x11.
3. 9 req0 strobes on consecutive cycles while i_Tx_Active=1 (FIFO_DEPTH=8) → 8 bytes stored, o_Req0_Ovf=1, 9th byte never transmitted.
4. FIFO full, push coincident with the IDLE-grant pop → no overflow, count stays 8, byte order preserved.
5. Assert reset during WAIT_DONE with i_Tx_Active=1, queue 0x55 → no o_Tx_DV until i_Tx_Active=0; then 0x55 is sent.
6. Spurious i_Tx_Done in IDLE with req1 0x20 pending → ignored. 0x20 is sent once and o_Req1_Ready pulses exactly once.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter: sequencing states,
// requester indices and default widths.
package uart_arb_pkg;

  localparam int DATA_W_DEFAULT     = 8;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  localparam logic REQ_CIPHER = 1'b0;
  localparam logic REQ_STATUS = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO for the cipher byte stream. A push while full is only
// accepted when a pop happens in the same cycle; overflow tracking is external.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push && rst_n) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between the buffered cipher stream (req0) and the
// status handshake source (req1). Define ARB_FIXED_PRIO_EN for strict req1 priority.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | waiting for a pending request and uart_tx idle
//   SEND      | o_Tx_DV high for this single cycle
//   WAIT_DONE | byte held, waiting for uart_tx frame complete
//   GAP       | one cycle for uart_tx Active to deassert
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Req0_DV,
  input  logic [DATA_W-1:0] i_Req0_Byte,
  output logic              o_Req0_Ovf,
  input  logic              i_Req1_Valid,
  input  logic [DATA_W-1:0] i_Req1_Byte,
  output logic              o_Req1_Ready,
  output logic              o_Tx_DV,
  output logic [DATA_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Grant,
  output logic              o_Busy
);

  arb_state_e                    state;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [DATA_W-1:0]             fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          p0;
  logic                          p1;
  logic                          can_grant;
  logic                          grant_sel;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .push      (i_Req0_DV),
    .push_data (i_Req0_Byte),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign p0 = !fifo_empty;
  assign p1 = i_Req1_Valid;

  // uart_tx keeps running through our reset, so Active gates every grant
  assign can_grant = i_Rst_n && (state == IDLE) && !i_Tx_Active && (p0 || p1);

`ifdef ARB_FIXED_PRIO_EN
  assign grant_sel = p1 ? REQ_STATUS : REQ_CIPHER;
`else
  logic last;
  assign grant_sel = (p0 && p1) ? ~last : p1;
`endif

  assign fifo_pop     = can_grant && (grant_sel == REQ_CIPHER);
  assign o_Req1_Ready = can_grant && (grant_sel == REQ_STATUS);
  assign o_Busy       = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Grant    <= 1'b0;
      o_Req0_Ovf <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
    end else begin
      o_Tx_DV <= 1'b0;
      if (i_Req0_DV && fifo_full && !fifo_pop) begin
        o_Req0_Ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (can_grant) begin
            o_Tx_Byte <= (grant_sel == REQ_STATUS) ? i_Req1_Byte : fifo_dout;
            o_Grant   <= grant_sel;
`ifndef ARB_FIXED_PRIO_EN
            last      <= grant_sel;
`endif
            o_Tx_DV   <= 1'b1;
            state     <= SEND;
          end
        end
        SEND:      state <= WAIT_DONE;
        WAIT_DONE: if (i_Tx_Done) state <= GAP;
        GAP:       state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
